multicycle_ctrl: RTL and testbench

- Main control FSM for the multicycle RISC-V core; sequences the shared ALU, register file, instruction/data memory and PC over several cycles per instruction.
- Issues alu_op to the existing ALU decoder, which resolves funct3/funct7 into ALUControl.
  - alu_op encoding: 00 add (address/PC), 01 I-type, 10 R-type, 11 branch.
- Stalls on a memory ready handshake.

---
 rtl/ctrl_pkg.sv | 58 +++++
 rtl/multicycle_ctrl_if.sv | 41 ++++
 rtl/ctrl_next_state.sv | 56 +++++
 rtl/multicycle_ctrl.sv | 145 ++++++++++++++
 tb/tb_multicycle_ctrl.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared definitions for the multicycle RISC-V control unit.
//   - state_e     : FSM state codes (also exported on state_o for debug)
//   - OP_*        : RV32I major opcodes recognised by the decoder
//   - ALUOP_*     : alu_op codes handed to the ALU decoder
//   - SRC_A_*/SRC_B_*/RES_* : datapath mux select codes
//   - is_retire_state() : states whose exit to FETCH completes an instruction
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADR   = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXEC_R    = 4'd6,
        S_EXEC_I    = 4'd7,
        S_ALU_WB    = 4'd8,
        S_BRANCH    = 4'd9,
        S_JAL       = 4'd10,
        S_ERROR     = 4'd15
    } state_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [1:0] ALUOP_ADD    = 2'b00;
    localparam logic [1:0] ALUOP_ITYPE  = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
    localparam logic [1:0] ALUOP_BRANCH = 2'b11;

    localparam logic [1:0] SRC_A_PC    = 2'b00;
    localparam logic [1:0] SRC_A_OLDPC = 2'b01;
    localparam logic [1:0] SRC_A_RS1   = 2'b10;

    localparam logic [1:0] SRC_B_RS2   = 2'b00;
    localparam logic [1:0] SRC_B_IMM   = 2'b01;
    localparam logic [1:0] SRC_B_FOUR  = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_MEMDATA   = 2'b01;
    localparam logic [1:0] RES_ALUDIRECT = 2'b10;

    // Leaving one of these states for FETCH means an instruction completed.
    function automatic logic is_retire_state(input state_e s);
        logic r;
        case (s)
            S_MEM_WB, S_MEM_WRITE, S_ALU_WB, S_BRANCH: r = 1'b1;
            default:                                   r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: control/status bundle between the control FSM and the
// multicycle datapath.
//   master (controller): inputs opcode, branch_cond, mem_ready; outputs all
//                        enables, mux selects, alu_op, illegal_instr,
//                        state_o and instret.
//   slave  (datapath)  : the mirror image.
interface multicycle_ctrl_if #(
    parameter int STATE_WIDTH = 4,
    parameter int CNT_WIDTH   = 32
);
    logic [6:0]             opcode;
    logic                   branch_cond;
    logic                   mem_ready;
    logic                   pc_write;
    logic                   ir_write;
    logic                   adr_src;
    logic                   mem_read;
    logic                   mem_write;
    logic                   reg_write;
    logic [1:0]             alu_src_a;
    logic [1:0]             alu_src_b;
    logic [1:0]             result_src;
    logic [1:0]             alu_op;
    logic                   illegal_instr;
    logic [STATE_WIDTH-1:0] state_o;
    logic [CNT_WIDTH-1:0]   instret;

    modport master (
        input  opcode, branch_cond, mem_ready,
        output pc_write, ir_write, adr_src, mem_read, mem_write, reg_write,
               alu_src_a, alu_src_b, result_src, alu_op,
               illegal_instr, state_o, instret
    );

    modport slave (
        output opcode, branch_cond, mem_ready,
        input  pc_write, ir_write, adr_src, mem_read, mem_write, reg_write,
               alu_src_a, alu_src_b, result_src, alu_op,
               illegal_instr, state_o, instret
    );
endinterface

// File: rtl/ctrl_next_state.sv
// ctrl_next_state: purely combinational next-state logic of the control FSM.
//   state      in  current state
//   opcode     in  instr[6:0]
//   mem_ready  in  memory access completed this cycle
//   state_next out state to load on the next clock edge
module ctrl_next_state
    import ctrl_pkg::*;
(
    input  state_e     state,
    input  logic [6:0] opcode,
    input  logic       mem_ready,
    output state_e     state_next
);

    // Next-state selection; unreachable codes fall back to FETCH.
    always_comb begin
        state_next = S_FETCH;
        case (state)
            S_FETCH: begin
                if (mem_ready) state_next = S_DECODE;
                else           state_next = S_FETCH;
            end
            S_DECODE: begin
                case (opcode)
                    OP_LOAD, OP_STORE: state_next = S_MEM_ADR;
                    OP_RTYPE:          state_next = S_EXEC_R;
                    OP_ITYPE:          state_next = S_EXEC_I;
                    OP_BRANCH:         state_next = S_BRANCH;
                    OP_JAL:            state_next = S_JAL;
                    default:           state_next = S_ERROR;
                endcase
            end
            S_MEM_ADR: begin
                if (opcode == OP_STORE) state_next = S_MEM_WRITE;
                else                    state_next = S_MEM_READ;
            end
            S_MEM_READ: begin
                if (mem_ready) state_next = S_MEM_WB;
                else           state_next = S_MEM_READ;
            end
            S_MEM_WRITE: begin
                if (mem_ready) state_next = S_FETCH;
                else           state_next = S_MEM_WRITE;
            end
            S_EXEC_R: state_next = S_ALU_WB;
            S_EXEC_I: state_next = S_ALU_WB;
            S_JAL:    state_next = S_ALU_WB;
            S_MEM_WB: state_next = S_FETCH;
            S_ALU_WB: state_next = S_FETCH;
            S_BRANCH: state_next = S_FETCH;
            S_ERROR:  state_next = S_ERROR;
            default:  state_next = S_FETCH;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: main control FSM of the multicycle RISC-V core.
//   clk    in  system clock, rising edge
//   rst_n  in  asynchronous active-low reset
//   bus    multicycle_ctrl_if.master: opcode/branch_cond/mem_ready in;
//          enables, mux selects, alu_op, illegal_instr, state_o, instret out
// Optional: define CTRL_PERF_CNT_EN to build the retired-instruction counter;
// otherwise instret is tied to zero.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int STATE_WIDTH = 4,
    parameter int CNT_WIDTH   = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    multicycle_ctrl_if.master  bus
);

    state_e state_r;
    state_e state_next_s;
    logic   illegal_r;

    logic       pc_write_s, ir_write_s, adr_src_s, mem_read_s, mem_write_s, reg_write_s;
    logic [1:0] alu_src_a_s, alu_src_b_s, result_src_s, alu_op_s;

    ctrl_next_state u_next_state (
        .state      (state_r),
        .opcode     (bus.opcode),
        .mem_ready  (bus.mem_ready),
        .state_next (state_next_s)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_r <= S_FETCH;
        else        state_r <= state_next_s;
    end

    // Sticky illegal-opcode flag, set as the FSM enters ERROR.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) illegal_r <= 1'b0;
        else        illegal_r <= illegal_r | (state_next_s == S_ERROR);
    end

    // Moore output decode; FETCH and BRANCH qualify their loads with inputs.
    always_comb begin
        pc_write_s   = 1'b0;
        ir_write_s   = 1'b0;
        adr_src_s    = 1'b0;
        mem_read_s   = 1'b0;
        mem_write_s  = 1'b0;
        reg_write_s  = 1'b0;
        alu_src_a_s  = SRC_A_PC;
        alu_src_b_s  = SRC_B_RS2;
        result_src_s = RES_ALUOUT;
        alu_op_s     = ALUOP_ADD;
        case (state_r)
            S_FETCH: begin
                mem_read_s   = 1'b1;
                alu_src_b_s  = SRC_B_FOUR;
                result_src_s = RES_ALUDIRECT;
                ir_write_s   = bus.mem_ready;
                pc_write_s   = bus.mem_ready;
            end
            S_DECODE: begin
                alu_src_a_s = SRC_A_OLDPC;
                alu_src_b_s = SRC_B_IMM;
            end
            S_MEM_ADR: begin
                alu_src_a_s = SRC_A_RS1;
                alu_src_b_s = SRC_B_IMM;
            end
            S_MEM_READ: begin
                mem_read_s = 1'b1;
                adr_src_s  = 1'b1;
            end
            S_MEM_WB: begin
                result_src_s = RES_MEMDATA;
                reg_write_s  = 1'b1;
            end
            S_MEM_WRITE: begin
                mem_write_s = 1'b1;
                adr_src_s   = 1'b1;
            end
            S_EXEC_R: begin
                alu_src_a_s = SRC_A_RS1;
                alu_op_s    = ALUOP_RTYPE;
            end
            S_EXEC_I: begin
                alu_src_a_s = SRC_A_RS1;
                alu_src_b_s = SRC_B_IMM;
                alu_op_s    = ALUOP_ITYPE;
            end
            S_ALU_WB: begin
                reg_write_s = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a_s = SRC_A_RS1;
                alu_op_s    = ALUOP_BRANCH;
                pc_write_s  = bus.branch_cond;
            end
            S_JAL: begin
                alu_src_a_s = SRC_A_OLDPC;
                alu_src_b_s = SRC_B_FOUR;
                pc_write_s  = 1'b1;
            end
            default: begin
                pc_write_s = 1'b0;
            end
        endcase
    end

    // Reset is folded in so no request or write escapes while rst_n is low,
    // even though FETCH itself would otherwise request a read.
    assign bus.pc_write      = pc_write_s  & rst_n;
    assign bus.ir_write      = ir_write_s  & rst_n;
    assign bus.mem_read      = mem_read_s  & rst_n;
    assign bus.mem_write     = mem_write_s & rst_n;
    assign bus.reg_write     = reg_write_s & rst_n;
    assign bus.adr_src       = adr_src_s;
    assign bus.alu_src_a     = alu_src_a_s;
    assign bus.alu_src_b     = alu_src_b_s;
    assign bus.result_src    = result_src_s;
    assign bus.alu_op        = alu_op_s;
    assign bus.illegal_instr = illegal_r;
    assign bus.state_o       = STATE_WIDTH'(state_r);

`ifdef CTRL_PERF_CNT_EN
    logic [CNT_WIDTH-1:0] instret_r;
    logic                 retire_s;

    assign retire_s = is_retire_state(state_r) && (state_next_s == S_FETCH);

    // Retired-instruction counter, wraps naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        instret_r <= '0;
        else if (retire_s) instret_r <= instret_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end

    assign bus.instret = instret_r;
`else
    assign bus.instret = '0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed plus randomized bench for multicycle_ctrl.
// An instruction-level model expands each opcode into its list of execution
// phases and retires an instruction when the list runs dry; a negedge compare
// process checks every output against it each cycle.
module tb_multicycle_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    multicycle_ctrl_if #(.STATE_WIDTH(4), .CNT_WIDTH(32)) bus ();

    multicycle_ctrl #(.STATE_WIDTH(4), .CNT_WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;
    bit cmp_en = 1'b0;

    // Model state
    int          m_state;
    int          m_plan[$];
    logic        m_illegal;
    logic [31:0] m_instret;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_state   = 0;
        m_plan.delete();
        m_illegal = 1'b0;
        m_instret = 32'd0;
    endtask

    // Phases an instruction walks through after DECODE.
    task automatic load_plan(input logic [6:0] op);
        case (op)
            7'b0000011: begin m_plan.push_back(2); m_plan.push_back(3); m_plan.push_back(4); end
            7'b0100011: begin m_plan.push_back(2); m_plan.push_back(5); end
            7'b0110011: begin m_plan.push_back(6); m_plan.push_back(8); end
            7'b0010011: begin m_plan.push_back(7); m_plan.push_back(8); end
            7'b1100011: m_plan.push_back(9);
            7'b1101111: begin m_plan.push_back(10); m_plan.push_back(8); end
            default:    m_plan.push_back(15);
        endcase
    endtask

    task automatic model_step();
        bit waiting;
        waiting = ((m_state == 0) || (m_state == 3) || (m_state == 5)) && !bus.mem_ready;
        if (!rst_n || waiting || m_state == 15) begin
            m_state = m_state;
        end else if (m_state == 0) begin
            m_state = 1;
        end else begin
            if (m_state == 1) load_plan(bus.opcode);
            if (m_plan.size() == 0) begin
                m_state   = 0;
                m_instret = m_instret + 32'd1;
            end else begin
                m_state = m_plan.pop_front();
            end
        end
        if (m_state == 15) m_illegal = 1'b1;
    endtask

    // {pc_write, ir_write, adr_src, mem_read, mem_write, reg_write, a, b, res, aluop}
    function automatic logic [13:0] exp_ctrl(input int st, input logic rn, input logic mr, input logic bc);
        logic pcw, irw, adr, mrd, mwr, rgw;
        logic [1:0] a, b, res, op;
        {pcw, irw, adr, mrd, mwr, rgw} = 6'b0;
        {a, b, res, op} = 8'b0;
        case (st)
            0:  begin mrd = 1'b1; b = 2'b10; res = 2'b10; pcw = mr; irw = mr; end
            1:  begin a = 2'b01; b = 2'b01; end
            2:  begin a = 2'b10; b = 2'b01; end
            3:  begin mrd = 1'b1; adr = 1'b1; end
            4:  begin res = 2'b01; rgw = 1'b1; end
            5:  begin mwr = 1'b1; adr = 1'b1; end
            6:  begin a = 2'b10; op = 2'b10; end
            7:  begin a = 2'b10; b = 2'b01; op = 2'b01; end
            8:  rgw = 1'b1;
            9:  begin a = 2'b10; op = 2'b11; pcw = bc; end
            10: begin a = 2'b01; b = 2'b10; pcw = 1'b1; end
            default: pcw = 1'b0;
        endcase
        if (!rn) {pcw, irw, mrd, mwr, rgw} = 5'b0;
        return {pcw, irw, adr, mrd, mwr, rgw, a, b, res, op};
    endfunction

    function automatic logic [31:0] exp_instret();
`ifdef CTRL_PERF_CNT_EN
        return m_instret;
`else
        return 32'd0;
`endif
    endfunction

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("ctrl_vec",
                  32'({bus.pc_write, bus.ir_write, bus.adr_src, bus.mem_read, bus.mem_write,
                       bus.reg_write, bus.alu_src_a, bus.alu_src_b, bus.result_src, bus.alu_op}),
                  32'(exp_ctrl(m_state, rst_n, bus.mem_ready, bus.branch_cond)));
            check("state", 32'(bus.state_o), 32'(m_state));
            check("illegal", 32'(bus.illegal_instr), 32'(m_illegal));
            check("instret", bus.instret, exp_instret());
        end
    end

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        cyc();
        cyc();
        rst_n = 1'b1;
    endtask

    task automatic run_instr(input logic [6:0] op, input logic bc);
        bit done;
        done = 1'b0;
        bus.opcode = op; bus.branch_cond = bc; bus.mem_ready = 1'b1;
        for (int i = 0; i < 20 && !done; i++) begin
            cyc();
            if (bus.state_o == 4'd0) done = 1'b1;
        end
        if (!done) check("run_instr_timeout", 32'd0, 32'd1);
    endtask

    localparam logic [6:0] LEGAL_OPS [6] = '{7'b0000011, 7'b0100011, 7'b0110011,
                                              7'b0010011, 7'b1100011, 7'b1101111};

    initial begin
        int err_cycles;
        rst_n = 1'b0;
        bus.opcode = 7'd0; bus.mem_ready = 1'b0; bus.branch_cond = 1'b0;
        model_reset();
        cmp_en = 1'b1;
        cyc(); cyc();
        check("rst_state", 32'(bus.state_o), 32'd0);
        check("rst_illegal", 32'(bus.illegal_instr), 32'd0);
        check("rst_instret", bus.instret, 32'd0);
        check("rst_mem_read", 32'(bus.mem_read), 32'd0);
        rst_n = 1'b1;
        #1 check("fetch_mem_read", 32'(bus.mem_read), 32'd1);

        // R-type: 0,1,6,8,0
        bus.opcode = 7'b0110011; bus.mem_ready = 1'b1;
        cyc(); check("r_s1", 32'(bus.state_o), 32'd1);
        cyc(); check("r_s6", 32'(bus.state_o), 32'd6);
               check("r_aluop", 32'(bus.alu_op), 32'd2);
        cyc(); check("r_s8", 32'(bus.state_o), 32'd8);
               check("r_regwr", 32'(bus.reg_write), 32'd1);
        cyc(); check("r_s0", 32'(bus.state_o), 32'd0);
               check("r_regwr0", 32'(bus.reg_write), 32'd0);

        // Load with a 3-cycle stall in MEM_READ
        bus.opcode = 7'b0000011;
        cyc(); cyc(); cyc();
        check("ld_s3", 32'(bus.state_o), 32'd3);
        bus.mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("ld_hold", 32'(bus.state_o), 32'd3);
            check("ld_rd_adr", 32'({bus.mem_read, bus.adr_src}), 32'd3);
        end
        bus.mem_ready = 1'b1;
        cyc(); check("ld_wb", 32'({bus.reg_write, bus.result_src}), 32'b101);
        cyc(); check("ld_s0", 32'(bus.state_o), 32'd0);

        // Branch taken then not taken
        bus.opcode = 7'b1100011; bus.branch_cond = 1'b1;
        cyc(); cyc(); check("br_t_pcw", 32'(bus.pc_write), 32'd1);
        cyc(); check("br_t_s0", 32'(bus.state_o), 32'd0);
        bus.branch_cond = 1'b0;
        cyc(); cyc(); check("br_n_pcw", 32'(bus.pc_write), 32'd0);
        cyc(); check("br_n_s0", 32'(bus.state_o), 32'd0);

        // Retire count: 3 R-type, 1 load, 1 untaken branch
        do_reset();
        for (int i = 0; i < 3; i++) run_instr(7'b0110011, 1'b0);
        run_instr(7'b0000011, 1'b0);
        run_instr(7'b1100011, 1'b0);
`ifdef CTRL_PERF_CNT_EN
        check("instret5", bus.instret, 32'd5);
`else
        check("instret0", bus.instret, 32'd0);
`endif

        // Illegal opcode
        bus.opcode = 7'b1111111;
        cyc(); cyc();
        check("ill_state", 32'(bus.state_o), 32'd15);
        for (int i = 0; i < 10; i++) begin
            cyc();
            check("ill_flag", 32'(bus.illegal_instr), 32'd1);
            check("ill_en", 32'({bus.pc_write, bus.ir_write, bus.mem_read, bus.mem_write, bus.reg_write}), 32'd0);
        end
        do_reset();
        check("ill_rst_state", 32'(bus.state_o), 32'd0);
        check("ill_rst_flag", 32'(bus.illegal_instr), 32'd0);

        // Async reset during a stalled store
        bus.opcode = 7'b0100011; bus.mem_ready = 1'b1;
        cyc(); cyc(); cyc();
        bus.mem_ready = 1'b0;
        cyc();
        #2 check("st_mem_write", 32'(bus.mem_write), 32'd1);
        rst_n = 1'b0;
        model_reset();
        #1;
        check("st_async_mw", 32'(bus.mem_write), 32'd0);
        check("st_async_state", 32'(bus.state_o), 32'd0);
        cyc();
        rst_n = 1'b1;

        // Randomized traffic
        err_cycles = 0;
        for (int n = 0; n < 1500; n++) begin
            if (m_state == 0) begin
                int r;
                r = int'($urandom_range(0, 19));
                if (r < 6) bus.opcode = LEGAL_OPS[r];
                else if (r < 18) bus.opcode = LEGAL_OPS[r % 6];
                else bus.opcode = 7'b1110011;
            end
            bus.mem_ready   = ($urandom_range(0, 3) != 0);
            bus.branch_cond = 1'($urandom_range(0, 1));
            if (m_state == 15) begin
                err_cycles++;
                if (err_cycles > 3) begin
                    err_cycles = 0;
                    do_reset();
                end
            end
            cyc();
        end

        @(negedge clk);
        #1;
        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
